// File: rtl/instruction_fetch_unit_if.sv
// Instruction-cache fetch channel: request/address out, valid/data back.
// The fetch unit drives the master side, the cache the slave side.
interface instruction_fetch_unit_if #(
  parameter int ADDR_WIDTH = 64
);
  logic                  imemReq;
  logic [ADDR_WIDTH-1:0] imemAddr;
  logic                  imemValid;
  logic [31:0]           imemData;

  modport master (
    output imemReq,
    output imemAddr,
    input  imemValid,
    input  imemData
  );

  modport slave (
    input  imemReq,
    input  imemAddr,
    output imemValid,
    output imemData
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// PC holder and fetch sequencer: fetches one word, holds it for the
// downstream stages, then steps or branches the PC on advance.
module instruction_fetch_unit #(
  parameter int                    ADDR_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                        clock,
  input  logic                        reset,
  instruction_fetch_unit_if.master    imem,
  output logic [31:0]                 instruction,
  output logic                        instrValid,
  output logic [ADDR_WIDTH-1:0]       pc,
  input  logic                        branch,
  input  logic                        unconditionalBranch,
  input  logic                        aluZero,
  input  logic                        advance,
  output logic                        halted
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [31:0]           r_instr;

  logic                  w_req;
  logic                  w_hold;
  logic                  w_halt;
  logic                  w_capture;
  logic                  w_pc_update;
  logic [ADDR_WIDTH-1:0] w_off_uncond;
  logic [ADDR_WIDTH-1:0] w_off_cond;
  logic [ADDR_WIDTH-1:0] w_off_sel;
  logic [ADDR_WIDTH-1:0] w_next_pc;

  // Word offsets: imm26 for B, imm19 (bits 23:5) for CBZ-style branches,
  // both sign-extended and scaled by 4 so pc stays word aligned.
  assign w_off_uncond = {{(ADDR_WIDTH-28){r_instr[25]}}, r_instr[25:0], 2'b00};
  assign w_off_cond   = {{(ADDR_WIDTH-21){r_instr[23]}}, r_instr[23:5], 2'b00};

  always_comb begin
    w_off_sel = ADDR_WIDTH'(4);
    if (unconditionalBranch)
      w_off_sel = w_off_uncond;
    else if (branch && aluZero)
      w_off_sel = w_off_cond;
  end

  assign w_next_pc = r_pc + w_off_sel;

  always_comb begin
    w_next_state = r_state;
    w_req        = 1'b0;
    w_hold       = 1'b0;
    w_halt       = 1'b0;
    w_capture    = 1'b0;
    w_pc_update  = 1'b0;
    case (r_state)
      IDLE: w_next_state = FETCH;
      FETCH: begin
        w_req = 1'b1;
        if (imem.imemValid) begin
          w_capture    = 1'b1;
          w_next_state = (imem.imemData == 32'h0) ? HALT : HOLD;
        end
      end
      HOLD: begin
        w_hold = 1'b1;
        if (advance) begin
          w_pc_update  = 1'b1;
          w_next_state = FETCH;
        end
      end
      HALT: w_halt = 1'b1;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_instr <= 32'h0;
    end else begin
      r_state <= w_next_state;
      if (w_capture)
        r_instr <= imem.imemData;
      if (w_pc_update)
        r_pc <= w_next_pc;
    end
  end

  assign imem.imemReq  = w_req;
  assign imem.imemAddr = r_pc;
  assign instruction   = r_instr;
  assign instrValid    = w_hold;
  assign pc            = r_pc;
  assign halted        = w_halt;

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Holds the program counter and fetches 32-bit instructions from the instruction cache through a request/valid handshake. Presents the latched instruction to the decoder/controller and waits for the downstream stages to finish. It then computes the next PC from the controller's `branch` / `unconditionalBranch` flags, the ALU zero flag and the branch immediate embedded in the held instruction. It is the stage directly upstream of the controller and closes the loop for the PC.

## Interface
Parameters:
- `ADDR_WIDTH`, 64: PC and instruction-address width.
- `RESET_PC`, 0: PC value loaded on reset; must be a multiple of 4.

Ports:
- `clock`  in  1  main clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `imemReq`  out  1  fetch request to instruction cache.
- `imemAddr`  out  ADDR_WIDTH  fetch address; equals `pc` while `imemReq`=1.
- `imemValid`  in  1  cache returns data this cycle.
- `imemData`  in  32  returned instruction word.
- `instruction`  out  32  latched instruction to controller.
- `instrValid`  out  1  `instruction` is valid and awaiting execution.
- `pc`  out  ADDR_WIDTH  address of `instruction` / current fetch.
- `branch`  in  1  conditional-branch flag from controller.
- `unconditionalBranch`  in  1  unconditional-branch flag from controller.
- `aluZero`  in  1  ALU zero result for the held instruction.
- `advance`  in  1  downstream has finished the held instruction; sampled only in HOLD.
- `halted`  out  1  an all-zero instruction was fetched; fetching stopped.

## Operation
- States: IDLE, FETCH, HOLD, HALT.
- IDLE: entered on reset. Next cycle → FETCH unconditionally.
- FETCH:
  - `imemReq`=1, `imemAddr`=`pc`.
  - Held every cycle until a cycle with `imemValid`=1; that cycle's `imemData` is latched into `instruction`.
  - Captured word 32'h0 → HALT; otherwise → HOLD.
- HOLD:
  - `instrValid`=1, `imemReq`=0; `instruction` and `pc` stable.
  - On `advance`=1 the PC updates and the state → FETCH.
- Next-PC rule (priority order, evaluated in the `advance` cycle):
  - `unconditionalBranch`=1 → `pc` + (sext(`instruction`[25:0]) << 2).
  - else `branch`=1 and `aluZero`=1 → `pc` + (sext(`instruction`[23:5]) << 2).
  - else → `pc` + 4.
- Arithmetic:
  - Offsets are sign-extended to ADDR_WIDTH before adding.
  - Addition is modulo 2^ADDR_WIDTH; wrap-around is silent.
  - `pc`[1:0] is always 00.
- HALT: `halted`=1, `instrValid`=0, `imemReq`=0; exits only via `reset`.
- `imemValid` outside FETCH is ignored; no state or output change.
- `advance` outside HOLD is ignored.
- The instruction cache is reset by the same `reset`. A response to a request abandoned by reset is not issued by the cache and is not handled here.

## Timing
- Reset values (cycle after `reset` sampled high): state IDLE, `pc`=RESET_PC, `instruction`=0, `instrValid`=0, `imemReq`=0, `halted`=0.
- Reset mid-FETCH or mid-HOLD takes effect at the next edge and overrides all other inputs.
- Latency from `reset` release:
  - First `imemReq` at cycle 2.
  - With a zero-wait cache (`imemValid` in the first FETCH cycle), `instrValid` rises at cycle 3.
- `instrValid` rises the cycle after the accepting `imemValid` cycle.
- The `advance` edge updates `pc` and drops `instrValid` simultaneously; the next `imemReq` is high that same cycle (no IDLE bubble).
- Steady state with zero-wait cache and `advance` asserted on the first HOLD cycle: one instruction every 2 cycles.
- `branch`, `unconditionalBranch` and `aluZero` are sampled only in the `advance` cycle.
- Simultaneous `unconditionalBranch` and `branch`: unconditional wins.

## Test plan
- Reset with RESET_PC=0x100, zero-wait cache returning ADD-type words, `advance` on the first HOLD cycle → `imemAddr` sequence 0x100, 0x104, 0x108, with `instrValid` high on alternate cycles.
- Cache delaying `imemValid` by 3 cycles → `imemReq` held high with `imemAddr` stable for 4 cycles; `instruction` equals data from the valid cycle only; a spurious `imemValid` in HOLD leaves `instruction` unchanged.
- At `pc`=0x200, instruction B with imm26=-2 (0x3FFFFFE), `unconditionalBranch`=1, `advance` → next `imemAddr`=0x1F8.
- At `pc`=0x40, CBZ with imm19=5:
  - `branch`=1, `aluZero`=1 → next address 0x54.
  - Same instruction with `aluZero`=0 → next address 0x44.
- At `pc`=0xFFFFFFFFFFFFFFFC, non-branch `advance` → `pc`=0.
- Fetch of 32'h0 → `halted`=1, `imemReq` stays 0 regardless of `advance`. `reset` asserted during a pending FETCH → next cycle `pc`=RESET_PC, `imemReq`=0, `halted`=0.
